// File: rtl/paddsb_seq_ctrl.sv
// paddsb_seq_ctrl: shared 4-bit saturating adder slice, round-robin
// between two requesters, one lane per cycle, valid/ready response.
module paddsb_seq_ctrl #(
    parameter int LANES = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req0_valid,
    output logic               o_req0_ready,
    input  logic [4*LANES-1:0] i_req0_a,
    input  logic [4*LANES-1:0] i_req0_b,
    input  logic               i_req1_valid,
    output logic               o_req1_ready,
    input  logic [4*LANES-1:0] i_req1_a,
    input  logic [4*LANES-1:0] i_req1_b,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic               o_rsp_id,
    output logic [4*LANES-1:0] o_rsp_sum,
    output logic [LANES-1:0]   o_rsp_sat,
    output logic               o_busy
);

    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_n;
    logic               r_rr;
    logic [CW-1:0]      r_cnt;
    logic [4*LANES-1:0] r_a;
    logic [4*LANES-1:0] r_b;
    logic               r_id;
    logic [4*LANES-1:0] r_sum;
    logic [LANES-1:0]   r_sat;

    logic               w_idle;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_acc;
    logic               w_last;
    logic [3:0]         w_la;
    logic [3:0]         w_lb;
    logic [3:0]         w_raw;
    logic [3:0]         w_lane;
    logic               w_lsat;

    // Round-robin grant: a lone requester always wins, ties go to r_rr.
    assign w_idle = (r_state == IDLE);
    assign w_gnt0 = i_req0_valid & (~i_req1_valid | ~r_rr);
    assign w_gnt1 = i_req1_valid & (~i_req0_valid | r_rr);
    assign w_acc  = w_idle & (w_gnt0 | w_gnt1);
    assign w_last = (r_cnt == LAST);

    assign o_req0_ready = w_idle & w_gnt0;
    assign o_req1_ready = w_idle & w_gnt1;
    assign o_rsp_valid  = (r_state == DONE);
    assign o_busy       = ~w_idle;
    assign o_rsp_id     = r_id;
    assign o_rsp_sum    = r_sum;
    assign o_rsp_sat    = r_sat;

    // Current lane: wrap-around add, then clamp on signed overflow.
    always_comb begin
        w_la   = r_a[4*r_cnt +: 4];
        w_lb   = r_b[4*r_cnt +: 4];
        w_raw  = w_la + w_lb;
        w_lane = w_raw;
        w_lsat = 1'b0;
        if (w_la[3] & w_lb[3] & ~w_raw[3]) begin
            w_lane = 4'h8;
            w_lsat = 1'b1;
        end else if (~w_la[3] & ~w_lb[3] & w_raw[3]) begin
            w_lane = 4'h7;
            w_lsat = 1'b1;
        end
    end

    // Next-state logic for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE:    if (w_acc) w_state_n = CALC;
            CALC:    if (w_last) w_state_n = DONE;
            DONE:    if (i_rsp_ready) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Operand capture, arbiter pointer and per-lane result update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr  <= 1'b0;
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_id  <= 1'b0;
            r_sum <= '0;
            r_sat <= '0;
        end else if (w_acc) begin
            r_a   <= w_gnt1 ? i_req1_a : i_req0_a;
            r_b   <= w_gnt1 ? i_req1_b : i_req0_b;
            r_id  <= w_gnt1;
            r_rr  <= ~w_gnt1;
            r_cnt <= '0;
            r_sum <= '0;
            r_sat <= '0;
        end else if (r_state == CALC) begin
            r_sum[4*r_cnt +: 4] <= w_lane;
            r_sat[r_cnt]        <= w_lsat;
            r_cnt               <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_paddsb_seq_ctrl.sv
// tb_paddsb_seq_ctrl: directed and random operations against a
// signed-arithmetic reference model with a round-robin tracker.
module tb_paddsb_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        r0v, r1v;
    logic        r0r, r1r;
    logic [15:0] a0, b0, a1, b1;
    logic        rv, rr_in, rid, busy;
    logic [15:0] rsum;
    logic [3:0]  rsat;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int prev_acc = 0;
    logic m_rr = 1'b0;

    paddsb_seq_ctrl #(.LANES(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (r0v),
        .o_req0_ready (r0r),
        .i_req0_a     (a0),
        .i_req0_b     (b0),
        .i_req1_valid (r1v),
        .o_req1_ready (r1r),
        .i_req1_a     (a1),
        .i_req1_b     (b1),
        .o_rsp_valid  (rv),
        .i_rsp_ready  (rr_in),
        .o_rsp_id     (rid),
        .o_rsp_sum    (rsum),
        .o_rsp_sat    (rsat),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each lane treated as a signed 4-bit number, summed as an integer
    // and clamped into [-8, 7].
    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] s, output logic [3:0] sat);
        int x;
        logic [3:0] la, lb;
        s = '0;
        sat = '0;
        for (int l = 0; l < 4; l++) begin
            la = a[4*l +: 4];
            lb = b[4*l +: 4];
            x = int'($signed(la)) + int'($signed(lb));
            if (x > 7) begin
                x = 7;
                sat[l] = 1'b1;
            end else if (x < -8) begin
                x = -8;
                sat[l] = 1'b1;
            end
            s[4*l +: 4] = x[3:0];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_rr = 1'b0;
    endtask

    task automatic do_op(input logic v0, input logic v1,
                         input logic [15:0] xa0, input logic [15:0] xb0,
                         input logic [15:0] xa1, input logic [15:0] xb1,
                         input int bp, input bit hold);
        logic g;
        logic [15:0] es;
        logic [3:0] esat;
        r0v = v0;
        r1v = v1;
        a0 = xa0;
        b0 = xb0;
        a1 = xa1;
        b1 = xb1;
        #1;
        if (v0 && v1) g = m_rr;
        else g = v1;
        chk("ready0", r0r, v0 && !g);
        chk("ready1", r1r, v1 && g);
        tick();
        prev_acc = last_acc;
        last_acc = cyc;
        if (!hold) begin
            r0v = 1'b0;
            r1v = 1'b0;
        end
        if (g) model(xa1, xb1, es, esat);
        else model(xa0, xb0, es, esat);
        m_rr = ~g;
        for (int i = 0; i < 4; i++) begin
            chk("calc_valid", rv, 1'b0);
            chk("calc_busy", busy, 1'b1);
            chk("calc_rdy", {r0r, r1r}, 2'b00);
            tick();
        end
        chk("rsp_valid", rv, 1'b1);
        chk("rsp_id", rid, g);
        chk("rsp_sum", rsum, es);
        chk("rsp_sat", rsat, esat);
        for (int i = 0; i < bp; i++) begin
            r0v = 1'b1;
            r1v = 1'b1;
            #1;
            chk("bp_rdy", {r0r, r1r}, 2'b00);
            tick();
            chk("bp_valid", rv, 1'b1);
            chk("bp_busy", busy, 1'b1);
            chk("bp_sum", rsum, es);
            chk("bp_sat", rsat, esat);
            chk("bp_id", rid, g);
        end
        if (!hold || bp > 0) begin
            r0v = 1'b0;
            r1v = 1'b0;
        end
        rr_in = 1'b1;
        tick();
        rr_in = 1'b0;
        chk("end_busy", busy, 1'b0);
        chk("end_valid", rv, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        r0v = 1'b0;
        r1v = 1'b0;
        a0 = '0;
        b0 = '0;
        a1 = '0;
        b1 = '0;
        rr_in = 1'b0;
        tick();
        tick();
        chk("rst_valid", rv, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdy", {r0r, r1r}, 2'b00);
        chk("rst_sum", rsum, 16'h0);
        chk("rst_sat", rsat, 4'h0);
        chk("rst_id", rid, 1'b0);

        // Valid during reset is not accepted.
        r0v = 1'b1;
        tick();
        rst = 1'b0;
        r0v = 1'b0;
        m_rr = 1'b0;
        #1;
        chk("rst_wins", busy, 1'b0);

        // Saturation mix.
        do_op(1, 0, 16'h783F, 16'h1F2F, 16'h0, 16'h0, 0, 0);
        chk("mix_sum", rsum, 16'h785E);
        chk("mix_lat", last_acc - prev_acc >= 0, 1'b1);

        // Contention after reset: 0, 1, 0.
        do_reset();
        do_op(1, 1, 16'h1234, 16'h1111, 16'h4321, 16'h2222, 0, 0);
        do_op(1, 1, 16'h1234, 16'h1111, 16'h4321, 16'h2222, 0, 0);
        do_op(1, 1, 16'hABCD, 16'h8888, 16'h7070, 16'h0707, 0, 0);
        chk("cont_third", rid, 1'b0);

        // Backpressure, all lanes positive overflow.
        do_op(0, 1, 16'h0, 16'h0, 16'h7777, 16'h7777, 3, 0);

        // Back-to-back issue from requester 1.
        for (int i = 0; i < 4; i++) begin
            do_op(0, 1, 16'h0, 16'h0, 16'h0000, 16'h0000, 0, 1);
            if (i > 0) chk("b2b_gap", last_acc - prev_acc, 6);
        end
        r1v = 1'b0;

        // Reset mid-CALC discards the op and clears the pointer.
        do_op(1, 0, 16'h0101, 16'h0202, 16'h0, 16'h0, 0, 0);
        r0v = 1'b1;
        a0 = 16'h5555;
        b0 = 16'h5555;
        tick();
        r0v = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_rr = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", rv, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_nopulse", rv, 1'b0);
            tick();
        end
        do_op(1, 1, 16'h2222, 16'h3333, 16'h4444, 16'h1111, 0, 0);

        // Reset while DONE is stalled clears the response registers.
        r1v = 1'b1;
        a1 = 16'h9999;
        b1 = 16'h1234;
        tick();
        r1v = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("done_stall", rv, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_rr = 1'b0;
        chk("donerst_valid", rv, 1'b0);
        chk("donerst_id", rid, 1'b0);
        chk("donerst_sum", rsum, 16'h0);
        chk("donerst_sat", rsat, 4'h0);

        // Negative, no saturation.
        do_op(1, 0, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 0, 0);

        // Random operations.
        for (int i = 0; i < 30; i++) begin
            int v;
            v = $urandom_range(1, 3);
            do_op(v[0], v[1], 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom),
                  $urandom_range(0, 2), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
